// File: rtl/uart_screen_tx_if.sv
`default_nettype none
//==============================================================================
// uart_screen_tx_if - start request, RAM read port and UART/status lines. Rev 1.0
//==============================================================================
interface uart_screen_tx_if;
  logic       START;
  logic [7:0] RDATA;
  logic [9:0] RADDR;
  logic       TXD;
  logic       BUSY;
  logic       DONE;

  modport master (output START, output RDATA, input RADDR, input TXD, input BUSY, input DONE);
  modport slave  (input START, input RDATA, output RADDR, output TXD, output BUSY, output DONE);
endinterface
`default_nettype wire

// File: rtl/uart_screen_tx.sv
`default_nettype none
//==============================================================================
// uart_screen_tx - dumps the tile RAM as hex text (CR LF per row) over UART 8N1. Rev 1.0
//==============================================================================
module uart_screen_tx #(
  parameter int CLK_HZ = 27000000,
  parameter int BAUD   = 115200,
  parameter int COLS   = 32,
  parameter int ROWS   = 28
) (
  input wire logic        CLK,
  input wire logic        RST,
  uart_screen_tx_if.slave bus
);
  localparam int            BAUD_DIV  = CLK_HZ / BAUD;
  localparam int            BW        = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
  localparam logic [4:0]    COL_LAST  = 5'(COLS - 1);
  localparam logic [4:0]    ROW_LAST  = 5'(ROWS - 1);

  typedef enum logic [1:0] {IDLE, FETCH, LOAD, SHIFT} state_t;
  typedef enum logic [1:0] {SEL_DATA, SEL_CR, SEL_LF} sel_t;

  state_t        state, state_nx;
  sel_t          sel, sel_nx;
  logic [4:0]    row, row_nx;
  logic [4:0]    col, col_nx;
  logic [BW-1:0] baud, baud_nx;
  logic [3:0]    bitn, bitn_nx;
  logic [9:0]    shreg, shreg_nx;
  logic          done, done_nx;
  logic [7:0]    hex_char;
  logic [7:0]    ch;
  logic          unused_hi;

  assign unused_hi = ^bus.RDATA[7:4];

  always_comb begin
    hex_char = (bus.RDATA[3:0] <= 4'd9) ? 8'h30 + {4'h0, bus.RDATA[3:0]}
                                        : 8'h37 + {4'h0, bus.RDATA[3:0]};
    ch = hex_char;
    if (sel == SEL_CR)      ch = 8'h0D;
    else if (sel == SEL_LF) ch = 8'h0A;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= IDLE;
      sel   <= SEL_DATA;
      row   <= '0;
      col   <= '0;
      baud  <= '0;
      bitn  <= '0;
      shreg <= '1;
      done  <= 1'b0;
    end else begin
      state <= state_nx;
      sel   <= sel_nx;
      row   <= row_nx;
      col   <= col_nx;
      baud  <= baud_nx;
      bitn  <= bitn_nx;
      shreg <= shreg_nx;
      done  <= done_nx;
    end
  end

  always_comb begin
    state_nx = state;
    sel_nx   = sel;
    row_nx   = row;
    col_nx   = col;
    baud_nx  = baud;
    bitn_nx  = bitn;
    shreg_nx = shreg;
    done_nx  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.START) begin
          state_nx = FETCH;
          sel_nx   = SEL_DATA;
          row_nx   = '0;
          col_nx   = '0;
        end
      end
      FETCH: state_nx = LOAD;
      LOAD: begin
        shreg_nx = {1'b1, ch, 1'b0};
        baud_nx  = '0;
        bitn_nx  = '0;
        state_nx = SHIFT;
      end
      SHIFT: begin
        if (baud != BAUD_LAST) begin
          baud_nx = baud + 1'b1;
        end else begin
          baud_nx  = '0;
          shreg_nx = {1'b1, shreg[9:1]};
          if (bitn != 4'd9) begin
            bitn_nx = bitn + 4'd1;
          end else begin
            // Character finished: pick what follows; every character re-enters FETCH.
            state_nx = FETCH;
            case (sel)
              SEL_DATA: begin
                if (col != COL_LAST) col_nx = col + 5'd1;
                else                 sel_nx = SEL_CR;
              end
              SEL_CR: sel_nx = SEL_LF;
              default: begin
                sel_nx = SEL_DATA;
                col_nx = '0;
                if (row == ROW_LAST) begin
                  state_nx = IDLE;
                  done_nx  = 1'b1;
                  row_nx   = '0;
                end else begin
                  row_nx = row + 5'd1;
                end
              end
            endcase
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign bus.RADDR = {row, col};
  assign bus.TXD   = (state == SHIFT) ? shreg[0] : 1'b1;
  assign bus.BUSY  = (state != IDLE);
  assign bus.DONE  = done;
endmodule
`default_nettype wire

// File: tb/tb_uart_screen_tx.sv
`default_nettype none
//==============================================================================
// tb_uart_screen_tx - table-driven and randomized dumps against a text/timing model. Rev 1.0
//==============================================================================
module tb_uart_screen_tx;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  uart_screen_tx_if ifa();
  uart_screen_tx_if ifb();

  logic [7:0] ram_a [1024];
  logic [7:0] ram_b [1024];
  assign ifa.RDATA = ram_a[ifa.RADDR];
  assign ifb.RDATA = ram_b[ifb.RADDR];

  uart_screen_tx #(.CLK_HZ(1000), .BAUD(100), .COLS(2), .ROWS(1)) dut_a (
    .CLK(CLK), .RST(RST), .bus(ifa.slave));
  uart_screen_tx #(.CLK_HZ(200), .BAUD(100), .COLS(32), .ROWS(28)) dut_b (
    .CLK(CLK), .RST(RST), .bus(ifb.slave));

  int         vectors = 0;
  int         miscompares = 0;
  bit         use_b = 1'b0;
  string      hexs = "0123456789ABCDEF";
  logic [7:0] got_q[$];

  logic       txd_m, busy_m, done_m;
  logic [9:0] raddr_m;
  always_comb begin
    txd_m   = use_b ? ifb.TXD   : ifa.TXD;
    busy_m  = use_b ? ifb.BUSY  : ifa.BUSY;
    done_m  = use_b ? ifb.DONE  : ifa.DONE;
    raddr_m = use_b ? ifb.RADDR : ifa.RADDR;
  end

  typedef struct {
    logic [7:0] d0, d1;
    logic [7:0] e0, e1;
  } vec_t;
  vec_t tbl[5];

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_start(input logic v);
    if (use_b) ifb.START = v;
    else       ifa.START = v;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Expected text is built from the RAM image; TXD is predicted per cycle from
  // the character index and the offset within its 2+10*DIV cycle slot.
  task automatic run_dump(input bit chained, input bit hold, input bit poke);
    int         cols, rows, div, per;
    logic [7:0] exp_q[$];
    int         adr_q[$];
    cols = use_b ? 32 : 2;
    rows = use_b ? 28 : 1;
    div  = use_b ? 2 : 10;
    per  = 2 + 10 * div;
    got_q.delete();
    for (int r = 0; r < rows; r++) begin
      for (int c = 0; c < cols; c++) begin
        logic [7:0] d;
        d = use_b ? ram_b[r*32+c] : ram_a[r*32+c];
        exp_q.push_back(hexs[d[3:0]]);
        adr_q.push_back(r * 32 + c);
      end
      exp_q.push_back(8'h0D); adr_q.push_back(-1);
      exp_q.push_back(8'h0A); adr_q.push_back(-1);
    end
    if (!chained) begin
      set_start(1'b1);
      tick();
    end
    set_start(hold);
    for (int k = 0; k < exp_q.size(); k++) begin
      logic [9:0] frame;
      logic [7:0] got;
      int         bad;
      frame = {1'b1, exp_q[k], 1'b0};
      got   = 8'h00;
      bad   = 0;
      for (int o = 0; o < per; o++) begin
        int   t;
        int   b;
        logic exp_txd;
        t = k * per + o;
        b = (o - 2) / div;
        exp_txd = (o < 2) ? 1'b1 : frame[b];
        if (txd_m !== exp_txd) bad++;
        if (busy_m !== 1'b1 || done_m !== 1'b0) bad++;
        if (o == 0 && adr_q[k] >= 0 && raddr_m !== 10'(adr_q[k])) bad++;
        if (o >= 2 && ((o - 2) % div) == div / 2 && b >= 1 && b <= 8) got[b-1] = txd_m;
        if (poke) begin
          if (t == 50 || t == 200) set_start(1'b1);
          if (t == 51 || t == 201) set_start(1'b0);
        end
        tick();
      end
      got_q.push_back(got);
      vectors++;
      if (bad != 0) begin
        miscompares++;
        $display("FAIL char%0d dut_%s: got 0x%02h expected 0x%02h, %0d bad cycles",
                 k, use_b ? "b" : "a", got, exp_q[k], bad);
      end
    end
    check("done_pulse", {19'h0, done_m, busy_m, txd_m, raddr_m}, {19'h0, 1'b1, 1'b0, 1'b1, 10'h000});
    tick();
    if (!hold) check("done_clear", {30'h0, done_m, busy_m}, 32'h0);
  endtask

  initial begin
    int bad_a, bad_b;
    tbl[0] = '{8'h00, 8'h01, 8'h30, 8'h31};
    tbl[1] = '{8'h0A, 8'h3F, 8'h41, 8'h46};
    tbl[2] = '{8'h09, 8'hF5, 8'h39, 8'h35};
    tbl[3] = '{8'hFE, 8'h7C, 8'h45, 8'h43};
    tbl[4] = '{8'hB6, 8'hD8, 8'h36, 8'h38};
    for (int i = 0; i < 1024; i++) begin
      ram_a[i] = 8'h00;
      ram_b[i] = 8'(i % 10);
    end
    ifa.START = 1'b1;
    ifb.START = 1'b1;

    // Reset held with START high: everything quiet.
    #2 RST = 1'b0;
    bad_a = 0;
    bad_b = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if ({ifa.TXD, ifa.BUSY, ifa.DONE, ifa.RADDR} !== {3'b100, 10'h000}) bad_a++;
      if ({ifb.TXD, ifb.BUSY, ifb.DONE, ifb.RADDR} !== {3'b100, 10'h000}) bad_b++;
    end
    check("reset_a_bad_cycles", bad_a, 0);
    check("reset_b_bad_cycles", bad_b, 0);
    ifa.START = 1'b0;
    ifb.START = 1'b0;
    #2 RST = 1'b1;
    tick();

    use_b = 1'b0;
    for (int v = 0; v < 5; v++) begin
      ram_a[0] = tbl[v].d0;
      ram_a[1] = tbl[v].d1;
      run_dump(1'b0, 1'b0, 1'b0);
      check($sformatf("tbl%0d_c0", v), got_q[0], tbl[v].e0);
      check($sformatf("tbl%0d_c1", v), got_q[1], tbl[v].e1);
      check($sformatf("tbl%0d_lf", v), got_q[3], 8'h0A);
    end

    for (int v = 0; v < 4; v++) begin
      ram_a[0] = 8'($urandom);
      ram_a[1] = 8'($urandom);
      run_dump(1'b0, 1'b0, 1'b0);
    end

    // START pulses mid-dump are ignored.
    ram_a[0] = 8'($urandom);
    ram_a[1] = 8'($urandom);
    run_dump(1'b0, 1'b0, 1'b1);

    // START held high: back-to-back dumps, one DONE each.
    run_dump(1'b0, 1'b1, 1'b0);
    run_dump(1'b1, 1'b0, 1'b0);

    // Reset in the middle of a low data bit of the second character.
    ram_a[0] = 8'h00;
    ram_a[1] = 8'h01;
    set_start(1'b1);
    tick();
    set_start(1'b0);
    repeat (102 + 2 + 35) tick();
    check("pre_abort_txd", {31'h0, ifa.TXD}, 32'h0);
    #1 RST = 1'b0;
    #1 check("abort_now", {29'h0, ifa.TXD, ifa.BUSY, ifa.DONE}, {29'h0, 3'b100});
    #2 RST = 1'b1;
    tick();
    run_dump(1'b0, 1'b0, 1'b0);
    check("restart_c0", got_q[0], 8'h30);

    // Full-size screen: i mod 10 pattern, then a random image.
    use_b = 1'b1;
    run_dump(1'b0, 1'b0, 1'b0);
    check("b_row0_c31", got_q[31], 8'h31);
    for (int i = 0; i < 1024; i++) ram_b[i] = 8'($urandom);
    run_dump(1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
`default_nettype wire
